// File: rtl/mole_hit_engine_pkg.sv
// Package mole_pkg: shared definitions for the whack-a-mole hit engine.
//   - game_state encoding (IDLE=0, PLAY=1, OVER=2)
//   - LFSR seed, tap mask and single-step helper
//   - default parameter constants used by the interface and the modules
package mole_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_N_HOLES    = 8;
    localparam int DEF_DB_CYCLES  = 16;
    localparam int DEF_MOLE_TICKS = 4;
    localparam int DEF_GAME_MOLES = 16;
    localparam int DEF_SCORE_W    = 8;

    // Fibonacci step: shift left, feed back the XOR of the tapped bits.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_hit_engine_if.sv
// Interface mole_hit_if: player/timebase inputs and game outputs of the
// mole hit engine.
//   start      raw start button
//   key        raw hit buttons, one per hole
//   tick       one-cycle game-time pulse
//   mole_mask  one-hot raised mole, zero when none
//   score      hits this game
//   miss_cnt   timed-out moles this game
//   game_state IDLE=0, PLAY=1, OVER=2
// master drives the inputs (board / bench), slave is the engine.
interface mole_hit_if
    import mole_pkg::*;
#(
    parameter int N_HOLES = DEF_N_HOLES,
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               start;
    logic [N_HOLES-1:0] key;
    logic               tick;
    logic [N_HOLES-1:0] mole_mask;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] miss_cnt;
    logic [1:0]         game_state;

    modport master (
        output start, key, tick,
        input  mole_mask, score, miss_cnt, game_state
    );

    modport slave (
        input  start, key, tick,
        output mole_mask, score, miss_cnt, game_state
    );
endinterface

// File: rtl/mole_hit_engine_debounce.sv
// key_debounce: one-bit button debouncer.
//   clk, rst_n  system clock, async active-low reset
//   raw         asynchronous button input
//   level       debounced level; follows raw only after DB_CYCLES
//               consecutive cycles of the new value
//   rise        one-cycle pulse, coincident with level going high
// The raw input is first brought into the clock domain with two flops.
module key_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= RELOAD;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            // Any sample matching the current level restarts the stability window.
            if (sync[1] == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync[1];
                rise  <= sync[1];
                cnt   <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/mole_hit_engine.sv
// mole_hit_engine: whack-a-mole game controller.
//   clk, rst_n  system clock, async active-low reset
//   bus         mole_hit_if slave: start/key/tick in; mole_mask, score,
//               miss_cnt, game_state out
// Optional build macro MOLE_PENALTY_EN: a wrong key edge while a mole is up
// (without the correct key in the same cycle) takes one point off the
// score, saturating at zero. Without it wrong keys are ignored.
//
// state | meaning
// IDLE  | after reset, waiting for a start edge
// PLAY  | game running; a mole is up, or the one-cycle gap before the next
// OVER  | all moles resolved; score/miss held until the next start edge
module mole_hit_engine
    import mole_pkg::*;
#(
    parameter int N_HOLES    = DEF_N_HOLES,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int MOLE_TICKS = DEF_MOLE_TICKS,
    parameter int GAME_MOLES = DEF_GAME_MOLES,
    parameter int SCORE_W    = DEF_SCORE_W
) (
    input  logic      clk,
    input  logic      rst_n,
    mole_hit_if.slave bus
);
    localparam int IDX_W  = $clog2(N_HOLES);
    localparam int TICK_W = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
    localparam int MC_W   = (GAME_MOLES > 1) ? $clog2(GAME_MOLES) : 1;
    localparam int HOLD   = DB_CYCLES + 4;
    localparam int HOLD_W = $clog2(HOLD + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_HOLES - 1);
    localparam logic [TICK_W-1:0]  TICK_LOAD = TICK_W'(MOLE_TICKS - 1);
    localparam logic [MC_W-1:0]    LAST_MOLE = MC_W'(GAME_MOLES - 1);
    localparam logic [SCORE_W-1:0] CNT_MAX   = '1;

    logic [N_HOLES-1:0] key_level, key_rise;
    logic               start_level, start_rise;
    logic               unused_levels;

    for (genvar i = 0; i < N_HOLES; i++) begin : g_key_db
        key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.key[i]),
            .level (key_level[i]),
            .rise  (key_rise[i])
        );
    end

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.start),
        .level (start_level),
        .rise  (start_rise)
    );

    // Only the rising edges drive the game.
    assign unused_levels = ^{key_level, start_level};

    // A start button held through reset release debounces high roughly
    // DB_CYCLES+2 cycles later; that rise is not a fresh press, so start
    // edges are ignored until this hold-off has run out.
    logic [HOLD_W-1:0] holdoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               holdoff <= HOLD_W'(HOLD);
        else if (holdoff != '0)   holdoff <= holdoff - 1'b1;
    end

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_step(lfsr);
    end

    game_state_t        state, state_next;
    logic [N_HOLES-1:0] mole_mask;
    logic [IDX_W-1:0]   prev_idx, rand_idx, pick_idx;
    logic [TICK_W-1:0]  tick_cnt;
    logic [MC_W-1:0]    mole_cnt;
    logic [SCORE_W-1:0] score, miss_cnt;
    logic               mole_up, hit, timeout, resolve, start_edge;
    logic               new_game, raise;

    assign mole_up    = |mole_mask;
    assign start_edge = start_rise && (holdoff == '0);
    assign hit        = mole_up && |(key_rise & mole_mask);
    assign timeout    = mole_up && bus.tick && (tick_cnt == '0);
    assign resolve    = hit || timeout;

    // Never raise the same hole twice in a row.
    always_comb begin
        rand_idx = IDX_W'(32'(lfsr[7:0]) % N_HOLES);
        pick_idx = rand_idx;
        if (rand_idx == prev_idx)
            pick_idx = (rand_idx == LAST_IDX) ? '0 : rand_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= GS_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        new_game   = 1'b0;
        raise      = 1'b0;
        case (state)
            GS_IDLE, GS_OVER: begin
                if (start_edge) begin
                    state_next = GS_PLAY;
                    new_game   = 1'b1;
                end
            end
            GS_PLAY: begin
                if (!mole_up)
                    raise = 1'b1;
                else if (resolve && mole_cnt == LAST_MOLE)
                    state_next = GS_OVER;
            end
            default: state_next = GS_IDLE;
        endcase
    end

`ifdef MOLE_PENALTY_EN
    logic wrong;
    assign wrong = mole_up && |(key_rise & ~mole_mask);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mole_mask <= '0;
            prev_idx  <= '0;
            tick_cnt  <= TICK_LOAD;
            mole_cnt  <= '0;
            score     <= '0;
            miss_cnt  <= '0;
        end else if (new_game) begin
            mole_mask <= '0;
            mole_cnt  <= '0;
            score     <= '0;
            miss_cnt  <= '0;
        end else if (raise) begin
            mole_mask <= N_HOLES'(1) << pick_idx;
            prev_idx  <= pick_idx;
            tick_cnt  <= TICK_LOAD;
        end else if (mole_up) begin
            // A hit wins over a coincident timeout; extra wrong keys in a
            // hit cycle are forgiven.
            if (hit) begin
                mole_mask <= '0;
                mole_cnt  <= mole_cnt + 1'b1;
                if (score != CNT_MAX) score <= score + 1'b1;
            end else begin
                if (timeout) begin
                    mole_mask <= '0;
                    mole_cnt  <= mole_cnt + 1'b1;
                    if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
                end else if (bus.tick) begin
                    tick_cnt <= tick_cnt - 1'b1;
                end
`ifdef MOLE_PENALTY_EN
                if (wrong && score != '0) score <= score - 1'b1;
`endif
            end
        end
    end

    assign bus.mole_mask  = mole_mask;
    assign bus.score      = score;
    assign bus.miss_cnt   = miss_cnt;
    assign bus.game_state = state;

endmodule

// File: tb/tb_mole_hit_engine.sv
// Self-checking bench for mole_hit_engine (default parameters).
// Expected score/miss values come from a counting model of the game rules
// driven by the bench's own choice of hit, miss or wrong key for each mole.
module tb_mole_hit_engine;
    import mole_pkg::*;

    localparam int N  = 8;
    localparam int DB = 16;
    localparam int MT = 4;
    localparam int GM = 16;
    localparam int SW = 8;
    // Two synchroniser flops plus the stability window: cycles from a raw
    // key change to the cycle in which its edge is acted on.
    localparam int KEY_LAT = DB + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mole_hit_if #(.N_HOLES(N), .SCORE_W(SW)) bus ();

    mole_hit_engine #(
        .N_HOLES(N), .DB_CYCLES(DB), .MOLE_TICKS(MT),
        .GAME_MOLES(GM), .SCORE_W(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_score, exp_miss, moles_done, prev_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_pulse();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        cyc(2);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int penalised(input int s);
`ifdef MOLE_PENALTY_EN
        return (s > 0) ? s - 1 : 0;
`else
        return s;
`endif
    endfunction

    task automatic start_game();
        int t;
        t = 0;
        bus.start = 1'b1;
        while (bus.game_state !== 2'd1 && t < 60) begin
            cyc(1);
            t++;
        end
        bus.start = 1'b0;
        chk("start_to_play", bus.game_state, 1);
        chk("score_cleared", bus.score, 0);
        chk("miss_cleared", bus.miss_cnt, 0);
        exp_score  = 0;
        exp_miss   = 0;
        moles_done = 0;
        prev_idx   = -1;
    endtask

    task automatic press_release(input int k);
        bus.key[k] = 1'b1;
        cyc(KEY_LAT + 2);
        bus.key[k] = 1'b0;
        cyc(KEY_LAT + 2);
    endtask

    // mode 0: let it time out, 1: hit it, 2: hit on the same cycle as the last tick
    task automatic resolve_mole(input int mode, input bit wrong);
        int t, idx, w, gap;
        logic [N-1:0] m;
        t = 0;
        while (bus.mole_mask == '0 && t < 10) begin
            cyc(1);
            t++;
        end
        m = bus.mole_mask;
        chk("mask_onehot", $countones(m), 1);
        idx = onehot_idx(m);
        if (prev_idx >= 0) chk("idx_differs", (idx != prev_idx), 1);
        prev_idx = idx;

        if (wrong) begin
            w = (idx + 1 + $urandom_range(0, N - 2)) % N;
            press_release(w);
            exp_score = penalised(exp_score);
            chk("wrong_key_score", bus.score, exp_score);
            chk("wrong_key_mole_held", bus.mole_mask[idx], 1);
        end

        case (mode)
            0: begin
                repeat (MT - 1) tick_pulse();
                chk("up_before_last_tick", bus.mole_mask[idx], 1);
                bus.tick = 1'b1;
                exp_miss++;
            end
            1: begin
                bus.key[idx] = 1'b1;
                exp_score++;
            end
            default: begin
                repeat (MT - 1) tick_pulse();
                chk("up_before_last_tick", bus.mole_mask[idx], 1);
                bus.key[idx] = 1'b1;
                cyc(KEY_LAT);
                bus.tick = 1'b1;
                exp_score++;
            end
        endcase

        t = 0;
        do begin
            cyc(1);
            bus.tick = 1'b0;
            t++;
        end while (bus.mole_mask !== '0 && t < 40);
        chk("mask_cleared", bus.mole_mask, 0);
        moles_done++;
        chk("score", bus.score, exp_score);
        chk("miss_cnt", bus.miss_cnt, exp_miss);

        if (moles_done == GM) begin
            chk("over_same_cycle", bus.game_state, 2);
        end else begin
            gap = 1;
            forever begin
                cyc(1);
                if (bus.mole_mask != '0 || gap >= 10) break;
                gap++;
            end
            chk("gap_one_cycle", gap, 1);
            chk("still_play", bus.game_state, 1);
        end
        bus.key = '0;
        cyc(KEY_LAT + 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  mode, w, idx;
        bit  wrong;

        bus.start = 1'b0;
        bus.key   = '0;
        bus.tick  = 1'b0;
        rst_n     = 1'b0;
        cyc(3);
        chk("rst_state", bus.game_state, 0);
        chk("rst_mask", bus.mole_mask, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_miss", bus.miss_cnt, 0);
        rst_n = 1'b1;
        cyc(30);

        // Short start glitches never reach the debounced level.
        for (int g = 0; g < 5; g++) begin
            bus.start = 1'b1;
            cyc($urandom_range(1, DB - 2));
            bus.start = 1'b0;
            cyc(DB + 4);
            chk("glitch_ignored", bus.game_state, 0);
        end

        press_release($urandom_range(0, N - 1));
        chk("idle_key_score", bus.score, 0);
        chk("idle_key_mask", bus.mole_mask, 0);

        // Game 1: first mole hit, second hit on the timeout tick, rest random.
        start_game();
        for (int i = 0; i < GM; i++) begin
            mode  = (i == 0) ? 1 : (i == 1) ? 2 : int'($urandom_range(0, 2));
            wrong = (i >= 2) && ($urandom_range(0, 3) == 0);
            resolve_mole(mode, wrong);
        end

        // Keys and ticks in OVER change nothing.
        press_release($urandom_range(0, N - 1));
        repeat (MT + 1) tick_pulse();
        chk("over_state_held", bus.game_state, 2);
        chk("over_mask_zero", bus.mole_mask, 0);
        chk("over_score_held", bus.score, exp_score);
        chk("over_miss_held", bus.miss_cnt, exp_miss);

        // Game 2: nobody plays.
        start_game();
        for (int i = 0; i < GM; i++) resolve_mole(0, 1'b0);
        chk("all_miss_total", bus.miss_cnt, GM);
        chk("all_miss_score", bus.score, 0);
        chk("all_miss_over", bus.game_state, 2);

        // Game 3: wrong keys after one hit, then reset mid-game.
        start_game();
        resolve_mole(1, 1'b0);
        idx = onehot_idx(bus.mole_mask);
        w = (idx + 1) % N;
        press_release(w);
        exp_score = penalised(exp_score);
        chk("penalty_first", bus.score, exp_score);
        w = (idx + 2) % N;
        press_release(w);
        exp_score = penalised(exp_score);
        chk("penalty_second", bus.score, exp_score);

        bus.start = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset_state", bus.game_state, 0);
        chk("midreset_mask", bus.mole_mask, 0);
        chk("midreset_score", bus.score, 0);
        chk("midreset_miss", bus.miss_cnt, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(60);
        chk("held_start_idle", bus.game_state, 0);
        chk("held_start_mask", bus.mole_mask, 0);
        bus.start = 1'b0;
        cyc(DB + 6);
        start_game();
        resolve_mole(int'($urandom_range(0, 2)), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
